// File: rtl/bcd_digit_collector.sv
// bcd_digit_collector
// Gathers keypad BCD digits into a right-justified packed word, launches the
// BCD-to-binary converter with a one-cycle init pulse, and holds the word
// stable until the converter reports done or the watchdog expires.
// Optional feature macro: BCD_AUTO_ENTER_EN (accepting the last free digit
// also starts the conversion).
module bcd_digit_collector #(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_digit_valid,
  input  logic [3:0]                    in_digit,
  input  logic                          in_enter,
  input  logic                          in_clear,
  input  logic                          in_conv_done,
  output logic [4*DIGITS-1:0]           out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]   out_count,
  output logic                          out_init,
  output logic                          out_busy,
  output logic                          out_err
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  state_t        state;
  logic [WW-1:0] wd;

  logic digit_ok;
  logic full;
  logic last_slot;
  logic wd_term;

  // Digit legality, register occupancy and watchdog terminal count
  always_comb begin
    digit_ok  = (in_digit <= 4'd9);
    full      = (out_count == CW'(DIGITS));
    last_slot = (out_count == CW'(DIGITS - 1));
    wd_term   = (wd == WW'(TIMEOUT - 1));
  end

  // Moore outputs decoded straight from the state register
  always_comb begin
    out_init = (state == LAUNCH);
    out_busy = (state != IDLE);
  end

  // Entry collection, launch handshake and watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_bcd   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
      wd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_clear) begin
            out_bcd   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
          end else if (in_enter) begin
            if (out_count != '0) state <= LAUNCH;
          end else if (in_digit_valid) begin
            if (!digit_ok || full) begin
              out_err <= 1'b1;
            end else begin
              out_bcd   <= {out_bcd[BW-5:0], in_digit};
              out_count <= out_count + 1'b1;
`ifdef BCD_AUTO_ENTER_EN
              if (last_slot) state <= LAUNCH;
`endif
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
          wd    <= '0;
        end
        WAIT: begin
          // done is tested first so it wins over a simultaneous terminal count
          if (in_conv_done) begin
            state     <= IDLE;
            out_bcd   <= '0;
            out_count <= '0;
          end else if (wd_term) begin
            state     <= IDLE;
            out_bcd   <= '0;
            out_count <= '0;
            out_err   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BCD_AUTO_ENTER_EN
  // last_slot only drives the auto-enter path
  logic unused_last_slot;
  always_comb unused_last_slot = last_slot;
`endif

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Directed bench for bcd_digit_collector with DIGITS=3, TIMEOUT=64.
module tb_bcd_digit_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_digit_valid;
  logic [3:0]  in_digit;
  logic        in_enter;
  logic        in_clear;
  logic        in_conv_done;
  logic [11:0] out_bcd;
  logic [1:0]  out_count;
  logic        out_init;
  logic        out_busy;
  logic        out_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  bcd_digit_collector #(.DIGITS(3), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_digit_valid(in_digit_valid), .in_digit(in_digit),
    .in_enter(in_enter), .in_clear(in_clear), .in_conv_done(in_conv_done),
    .out_bcd(out_bcd), .out_count(out_count), .out_init(out_init),
    .out_busy(out_busy), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    in_digit = d;
    in_digit_valid = 1'b1;
    step();
    in_digit_valid = 1'b0;
  endtask

  task automatic press_enter();
    in_enter = 1'b1;
    step();
    in_enter = 1'b0;
  endtask

  task automatic press_clear();
    in_clear = 1'b1;
    step();
    in_clear = 1'b0;
  endtask

  task automatic pulse_done();
    in_conv_done = 1'b1;
    step();
    in_conv_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_digit_valid = 1'b0; in_digit = 4'd0; in_enter = 1'b0;
    in_clear = 1'b0; in_conv_done = 1'b0;
    #12;
    n_total++;
    if ({out_bcd, out_count, out_init, out_busy, out_err} !== 17'd0)
      $display("FAIL reset_outputs: got bcd=%h cnt=%0d init=%b busy=%b err=%b, expected all 0",
               out_bcd, out_count, out_init, out_busy, out_err);
    else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    send_digit(4'd2); send_digit(4'd5); send_digit(4'd5);
    n_total++;
    if (out_bcd !== 12'h255 || out_count !== 2'd3)
      $display("FAIL basic_entry: got bcd=%h cnt=%0d, expected 255 cnt=3", out_bcd, out_count);
    else n_pass++;
    press_enter();
    n_total++;
    if (out_init !== 1'b1 || out_busy !== 1'b1)
      $display("FAIL basic_launch: got init=%b busy=%b, expected 1 1", out_init, out_busy);
    else n_pass++;
    step();
    n_total++;
    if (out_init !== 1'b0 || out_busy !== 1'b1 || out_bcd !== 12'h255)
      $display("FAIL basic_wait: got init=%b busy=%b bcd=%h, expected 0 1 255",
               out_init, out_busy, out_bcd);
    else n_pass++;
    pulse_done();
    n_total++;
    if (out_busy !== 1'b0 || out_bcd !== 12'h000 || out_count !== 2'd0 || out_err !== 1'b0)
      $display("FAIL basic_done: got busy=%b bcd=%h cnt=%0d err=%b, expected 0 000 0 0",
               out_busy, out_bcd, out_count, out_err);
    else n_pass++;
  endtask

  task automatic test_bad_digit();
    send_digit(4'd8);
    send_digit(4'hA);
    n_total++;
    if (out_bcd !== 12'h008 || out_count !== 2'd1 || out_err !== 1'b1)
      $display("FAIL bad_digit: got bcd=%h cnt=%0d err=%b, expected 008 1 1",
               out_bcd, out_count, out_err);
    else n_pass++;
    press_clear();
    n_total++;
    if (out_err !== 1'b0 || out_bcd !== 12'h000 || out_count !== 2'd0)
      $display("FAIL clear: got err=%b bcd=%h cnt=%0d, expected 0 000 0",
               out_err, out_bcd, out_count);
    else n_pass++;
  endtask

  task automatic test_priority();
    press_enter();
    n_total++;
    if (out_busy !== 1'b0 || out_err !== 1'b0)
      $display("FAIL empty_enter: got busy=%b err=%b, expected 0 0", out_busy, out_err);
    else n_pass++;
    send_digit(4'd6);
    in_clear = 1'b1; in_enter = 1'b1; in_digit_valid = 1'b1; in_digit = 4'd3;
    step();
    in_clear = 1'b0; in_enter = 1'b0; in_digit_valid = 1'b0;
    n_total++;
    if (out_count !== 2'd0 || out_bcd !== 12'h000 || out_busy !== 1'b0)
      $display("FAIL clear_wins: got cnt=%0d bcd=%h busy=%b, expected 0 000 0",
               out_count, out_bcd, out_busy);
    else n_pass++;
    send_digit(4'd9);
    pulse_done();
    n_total++;
    if (out_bcd !== 12'h009 || out_busy !== 1'b0)
      $display("FAIL done_in_idle: got bcd=%h busy=%b, expected 009 0", out_bcd, out_busy);
    else n_pass++;
    in_enter = 1'b1; in_digit_valid = 1'b1; in_digit = 4'd1;
    step();
    in_enter = 1'b0; in_digit_valid = 1'b0;
    n_total++;
    if (out_init !== 1'b1 || out_bcd !== 12'h009 || out_count !== 2'd1)
      $display("FAIL enter_wins: got init=%b bcd=%h cnt=%0d, expected 1 009 1",
               out_init, out_bcd, out_count);
    else n_pass++;
    // done during LAUNCH must not short-circuit the handshake
    pulse_done();
    n_total++;
    if (out_busy !== 1'b1 || out_init !== 1'b0)
      $display("FAIL done_in_launch: got busy=%b init=%b, expected 1 0", out_busy, out_init);
    else n_pass++;
    pulse_done();
  endtask

  task automatic test_full();
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
`ifdef BCD_AUTO_ENTER_EN
    n_total++;
    if (out_init !== 1'b1 || out_bcd !== 12'h123)
      $display("FAIL auto_full: got init=%b bcd=%h, expected 1 123", out_init, out_bcd);
    else n_pass++;
    step();
    pulse_done();
`else
    send_digit(4'd4);
    n_total++;
    if (out_bcd !== 12'h123 || out_err !== 1'b1 || out_count !== 2'd3)
      $display("FAIL overflow: got bcd=%h err=%b cnt=%0d, expected 123 1 3",
               out_bcd, out_err, out_count);
    else n_pass++;
    press_clear();
`endif
  endtask

  task automatic test_timeout();
    send_digit(4'd7);
    press_enter();
    step();
    for (int i = 0; i < 63; i++) step();
    n_total++;
    if (out_busy !== 1'b1)
      $display("FAIL wd_before_term: got busy=%b, expected 1", out_busy);
    else n_pass++;
    step();
    n_total++;
    if (out_busy !== 1'b0 || out_err !== 1'b1 || out_bcd !== 12'h000 || out_count !== 2'd0)
      $display("FAIL wd_abort: got busy=%b err=%b bcd=%h cnt=%0d, expected 0 1 000 0",
               out_busy, out_err, out_bcd, out_count);
    else n_pass++;
    press_clear();
    send_digit(4'd7);
    press_enter();
    step();
    for (int i = 0; i < 63; i++) step();
    pulse_done();
    n_total++;
    if (out_busy !== 1'b0 || out_err !== 1'b0 || out_bcd !== 12'h000)
      $display("FAIL done_at_term: got busy=%b err=%b bcd=%h, expected 0 0 000",
               out_busy, out_err, out_bcd);
    else n_pass++;
  endtask

  task automatic test_wait_ignore();
    send_digit(4'd4); send_digit(4'd2);
    press_enter();
    step();
    send_digit(4'd7);
    press_enter();
    press_clear();
    n_total++;
    if (out_bcd !== 12'h042 || out_count !== 2'd2 || out_busy !== 1'b1 || out_init !== 1'b0)
      $display("FAIL wait_ignore: got bcd=%h cnt=%0d busy=%b init=%b, expected 042 2 1 0",
               out_bcd, out_count, out_busy, out_init);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if ({out_bcd, out_count, out_init, out_busy, out_err} !== 17'd0)
      $display("FAIL async_reset: got bcd=%h cnt=%0d init=%b busy=%b err=%b, expected all 0",
               out_bcd, out_count, out_init, out_busy, out_err);
    else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_auto_enter();
`ifdef BCD_AUTO_ENTER_EN
    send_digit(4'd1); send_digit(4'd0); send_digit(4'd0);
    n_total++;
    if (out_init !== 1'b1 || out_bcd !== 12'h100)
      $display("FAIL auto_enter: got init=%b bcd=%h, expected 1 100", out_init, out_bcd);
    else n_pass++;
    step();
    pulse_done();
`else
    send_digit(4'd1); send_digit(4'd0); send_digit(4'd0);
    n_total++;
    if (out_busy !== 1'b0 || out_bcd !== 12'h100 || out_count !== 2'd3)
      $display("FAIL no_auto_enter: got busy=%b bcd=%h cnt=%0d, expected 0 100 3",
               out_busy, out_bcd, out_count);
    else n_pass++;
    press_clear();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_digit();
    test_priority();
    test_full();
    test_timeout();
    test_wait_ignore();
    test_auto_enter();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
